acc_sequencer: RTL and testbench
================================

Name: acc_sequencer

Overview:
- Instruction fetch/issue stage sitting directly upstream of the accumulator.
- Fetches 36-bit instruction words from instruction memory over a req/valid handshake and decodes them.
- Drives the accumulator's opcode/operand inputs for exactly one cycle per ADD/LOAD.
- Resolves JMP/JZ/HALT locally; JZ tests the accumulator output fed back as acc_in.

Parameters:
- AW, 8, instruction address (PC) width.
- START_ADDR, 0, PC value loaded on start.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins execution from IDLE or HALTED
- imem_req  out  1  fetch request, held until accepted
- imem_addr  out  AW  fetch address (= PC)
- imem_valid  in  1  memory data valid; accepts fetch when imem_req=1
- imem_data  in  36  instruction: [35:32] opcode, [31:0] operand
- acc_in  in  32  accumulator output, used by JZ
- opcode  out  4  to accumulator; NOP (4'hF) when not issuing
- operand  out  32  to accumulator
- halted  out  1  high in HALTED
- err  out  1  sticky illegal-opcode flag
- instr_count  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset: asynchronous, active-high; clock clk. On reset: state IDLE, pc=START_ADDR, imem_req=0, opcode=4'hF, operand=0, halted=0, err=0, instr_count=0. Reset mid-fetch abandons the request; a late imem_valid is ignored.
- Opcodes (4-bit): ADD=0, LOAD=2, JMP=8, JZ=9, HALT=E, NOP=F. All others are illegal.
- States: IDLE, FETCH, EXEC, HALTED.
- IDLE:
  - start=1 -> pc=START_ADDR, go to FETCH.
  - start is ignored in FETCH and EXEC.
- FETCH:
  - imem_req=1, imem_addr=pc, both held stable until imem_valid.
  - imem_valid=1 -> latch imem_data into the instruction register (ir), drop imem_req, go to EXEC.
  - Zero-wait memory (imem_valid in the first request cycle) is legal.
- EXEC (exactly one cycle; decode ir):
  - ADD/LOAD: at the exiting edge, register opcode/operand from ir; pc=pc+1; go to FETCH.
  - NOP: pc=pc+1; go to FETCH; nothing issued.
  - JMP: pc=operand[AW-1:0]; go to FETCH.
  - JZ: pc=operand[AW-1:0] if acc_in==0, else pc+1; go to FETCH.
  - HALT: go to HALTED; pc unchanged.
  - Illegal: err<=1 (sticky until reset); treated as NOP.
- Issue timing:
  - opcode/operand are registered and hold a non-NOP value for exactly one cycle: the first FETCH cycle after EXEC. They return to NOP/0 at the next edge.
  - The accumulator updates at the end of that cycle, so acc_in is valid in any subsequent EXEC, including with zero-wait memory. No hazard stall is needed.
- HALTED:
  - halted=1, opcode=NOP, imem_req=0.
  - start=1 -> halted=0, pc=START_ADDR, go to FETCH.
- PC arithmetic: pc+1 wraps modulo 2^AW. Jump targets use operand bits [AW-1:0]; upper bits are ignored.
- Throughput: with zero-wait memory, 2 cycles per instruction.

Optional Feature:
- Macro ACC_SEQ_PERF_EN.
- Defined: instr_count increments by 1 on every EXEC cycle, all opcodes including illegal and HALT. It wraps at 2^32 and is cleared by reset and by start.
- Undefined: no counter register is built; instr_count is tied to 0.

Decomposition:
- Shared package acc_pkg:
  - opcode localparams (ADD, LOAD, JMP, JZ, HALT, NOP), 4 bits wide; the accumulator imports the same constants.
  - instruction field positions and instruction width (36).
  - state encoding typedef.
- No sub-module; a single FSM plus datapath registers.

Test Plan:
- Program at 0: LOAD 5, ADD 7, HALT; zero-wait memory; start pulse -> opcode=2 with operand=5 for one cycle, then opcode=0 with operand=7 for one cycle; accumulator ends at 12; halted=1 after 6 cycles.
- Same program with imem_valid delayed 3 cycles per fetch -> imem_addr stable while imem_req=1; identical opcode sequence; opcode stays F during waits.
- LOAD 0, JZ 4, ADD 1, HALT, (addr 4) ADD 9, HALT -> branch taken, accumulator=9. Repeat with LOAD 3 -> branch not taken, accumulator=4.
- AW=4, JMP 15, word 15=NOP, word 0=HALT -> pc wraps 15->0, halts; JMP operand 0x12 -> target 2.
- Opcode 4'h5 in program -> err=1 and stays set; execution continues; accumulator unaffected.
- Reset asserted mid-FETCH with imem_valid arriving the next cycle -> imem_req=0, state IDLE, data ignored. With ACC_SEQ_PERF_EN defined, instr_count=3 after the first program.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator and its fetch/issue sequencer:
// opcodes, instruction field layout and sequencer state encoding.
package acc_pkg;

    localparam int INSTR_W  = 36;
    localparam int OPC_MSB  = 35;
    localparam int OPC_LSB  = 32;
    localparam int OPND_MSB = 31;
    localparam int OPND_LSB = 0;
    localparam int OPND_W   = OPND_MSB - OPND_LSB + 1;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_LOAD = 4'h2;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_NOP  = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALTED
    } state_e;

endpackage

// File: rtl/acc_sequencer.sv
// Fetch/decode/issue stage in front of the accumulator.
// Define ACC_SEQ_PERF_EN to build the retired-instruction counter.
module acc_sequencer
    import acc_pkg::*;
#(
    parameter int            AW         = 8,
    parameter logic [AW-1:0] START_ADDR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               imem_req,
    output logic [AW-1:0]      imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic [31:0]        acc_in,
    output logic [3:0]         opcode,
    output logic [31:0]        operand,
    output logic               halted,
    output logic               err,
    output logic [31:0]        instr_count
);

    state_e               state_q, state_d;
    logic [AW-1:0]        pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [3:0]           opcode_q, opcode_d;
    logic [OPND_W-1:0]    operand_q, operand_d;
    logic                 err_q, err_d;

    logic [3:0]           ir_opc;
    logic [OPND_W-1:0]    ir_opnd;
    logic                 restart;
    logic                 exec;

    assign ir_opc  = ir_q[OPC_MSB:OPC_LSB];
    assign ir_opnd = ir_q[OPND_MSB:OPND_LSB];
    assign exec    = (state_q == S_EXEC);
    assign restart = start && (state_q == S_IDLE || state_q == S_HALTED);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        opcode_d  = OP_NOP;
        operand_d = '0;
        err_d     = err_q;
        unique case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = START_ADDR;
                end
            end
            S_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_q + 1'b1;
                unique case (ir_opc)
                    OP_ADD, OP_LOAD: begin
                        // Issue slot is the first FETCH cycle that follows
                        opcode_d  = ir_opc;
                        operand_d = ir_opnd;
                    end
                    OP_NOP: begin
                    end
                    OP_JMP: pc_d = ir_opnd[AW-1:0];
                    OP_JZ: begin
                        if (acc_in == '0) pc_d = ir_opnd[AW-1:0];
                    end
                    OP_HALT: begin
                        state_d = S_HALTED;
                        pc_d    = pc_q;
                    end
                    default: err_d = 1'b1;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= START_ADDR;
            ir_q      <= '0;
            opcode_q  <= OP_NOP;
            operand_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            err_q     <= err_d;
        end
    end

`ifdef ACC_SEQ_PERF_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart)   cnt_d = '0;
        else if (exec) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign instr_count = cnt_q;
`else
    logic unused_perf;
    assign unused_perf = restart ^ exec;
    assign instr_count = '0;
`endif

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign opcode    = opcode_q;
    assign operand   = operand_q;
    assign halted    = (state_q == S_HALTED);
    assign err       = err_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer: program table, a small accumulator
// model and memory responders, plus hand-written reset/wrap sequences.
module tb_acc_sequencer;
    import acc_pkg::*;

`ifdef ACC_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [35:0] imem_data;
    logic [31:0] acc;
    logic [3:0]  opcode;
    logic [31:0] operand;
    logic        halted;
    logic        err;
    logic [31:0] instr_count;

    logic        start4 = 1'b0;
    logic        imem_req4;
    logic [3:0]  imem_addr4;
    logic [35:0] imem_data4;
    logic [3:0]  opcode4;
    logic [31:0] operand4;
    logic        halted4;
    logic        err4;
    logic [31:0] instr_count4;
    logic [31:0] acc_zero = 32'd0;

    always #5 clk = ~clk;

    acc_sequencer #(.AW(8), .START_ADDR(8'd0)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .acc_in(acc), .opcode(opcode), .operand(operand),
        .halted(halted), .err(err), .instr_count(instr_count)
    );

    acc_sequencer #(.AW(4), .START_ADDR(4'd13)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4),
        .imem_req(imem_req4), .imem_addr(imem_addr4),
        .imem_valid(imem_req4), .imem_data(imem_data4),
        .acc_in(acc_zero), .opcode(opcode4), .operand(operand4),
        .halted(halted4), .err(err4), .instr_count(instr_count4)
    );

    // Memory models
    logic [35:0] mem [256];
    logic [35:0] mem4 [16];
    int          wait_cfg = 0;
    int          wait_cnt = 0;
    logic        manual_mode = 1'b0;
    logic        manual_valid = 1'b0;

    assign imem_data  = mem[imem_addr];
    assign imem_data4 = mem4[imem_addr4];
    assign imem_valid = manual_mode ? manual_valid
                                    : (imem_req && wait_cnt >= wait_cfg);

    always @(posedge clk) begin
        if (imem_req && !imem_valid) wait_cnt <= wait_cnt + 1;
        else                         wait_cnt <= 0;
    end

    // Reference accumulator
    always @(posedge clk or posedge reset) begin
        if (reset) acc <= 32'd0;
        else if (opcode == OP_LOAD) acc <= operand;
        else if (opcode == OP_ADD)  acc <= acc + operand;
    end

    // Monitors
    logic [35:0] iss_q[$];
    logic [3:0]  addr4_q[$];
    int          proto_err = 0;
    int          iss4 = 0;
    logic        prev_wait = 1'b0;
    logic [7:0]  prev_addr = 8'd0;

    always @(posedge clk) begin
        prev_wait <= imem_req && !imem_valid;
        prev_addr <= imem_addr;
    end

    always @(negedge clk) begin
        if (opcode != OP_NOP) iss_q.push_back({opcode, operand});
        if (opcode == OP_NOP && operand != 32'd0) proto_err++;
        if (prev_wait && imem_req && imem_addr != prev_addr) proto_err++;
        if (imem_req4) addr4_q.push_back(imem_addr4);
        if (opcode4 != OP_NOP) iss4++;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [35:0] act,
                       input logic [35:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] ins(input logic [3:0] op,
                                        input logic [31:0] d);
        return {op, d};
    endfunction

    typedef struct {
        logic [7:0][35:0] prog;
        int               wait_cyc;
        int               n_instr;
        logic [31:0]      exp_acc;
        logic             exp_err;
        int               n_iss;
        logic [3:0][35:0] iss;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_halt(output int cyc);
        cyc = 0;
        while (cyc < 400 && !halted) begin
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic check_end(input int k, input int cyc);
        int exp_cnt;
        exp_cnt = PERF ? vecs[k].n_instr : 0;
        chk($sformatf("v%0d cycles", k), 36'(cyc),
            36'(vecs[k].n_instr * (2 + vecs[k].wait_cyc)));
        chk($sformatf("v%0d acc", k), 36'(acc), 36'(vecs[k].exp_acc));
        chk($sformatf("v%0d err", k), 36'(err), 36'(vecs[k].exp_err));
        chk($sformatf("v%0d count", k), 36'(instr_count), 36'(exp_cnt));
        chk($sformatf("v%0d protocol", k), 36'(proto_err), 36'd0);
        chk($sformatf("v%0d n_issue", k), 36'(iss_q.size()),
            36'(vecs[k].n_iss));
        for (int j = 0; j < vecs[k].n_iss && j < iss_q.size(); j++)
            chk($sformatf("v%0d issue%0d", k, j), iss_q[j], vecs[k].iss[j]);
    endtask

    initial begin
        int cyc;

        for (int i = 0; i < NV; i++) begin
            vecs[i].prog     = {8{ins(OP_HALT, 32'd0)}};
            vecs[i].wait_cyc = 0;
            vecs[i].exp_err  = 1'b0;
            vecs[i].iss      = '0;
        end
        // LOAD 5, ADD 7, HALT
        vecs[0].prog[0] = ins(OP_LOAD, 32'd5);
        vecs[0].prog[1] = ins(OP_ADD, 32'd7);
        vecs[0].n_instr = 3;  vecs[0].exp_acc = 32'd12;
        vecs[0].n_iss   = 2;
        vecs[0].iss[0]  = ins(OP_LOAD, 32'd5);
        vecs[0].iss[1]  = ins(OP_ADD, 32'd7);
        // JZ taken
        vecs[1].prog[0] = ins(OP_LOAD, 32'd0);
        vecs[1].prog[1] = ins(OP_JZ, 32'd4);
        vecs[1].prog[2] = ins(OP_ADD, 32'd1);
        vecs[1].prog[4] = ins(OP_ADD, 32'd9);
        vecs[1].n_instr = 4;  vecs[1].exp_acc = 32'd9;
        vecs[1].n_iss   = 2;
        vecs[1].iss[0]  = ins(OP_LOAD, 32'd0);
        vecs[1].iss[1]  = ins(OP_ADD, 32'd9);
        // JZ not taken
        vecs[2].prog    = vecs[1].prog;
        vecs[2].prog[0] = ins(OP_LOAD, 32'd3);
        vecs[2].n_instr = 4;  vecs[2].exp_acc = 32'd4;
        vecs[2].n_iss   = 2;
        vecs[2].iss[0]  = ins(OP_LOAD, 32'd3);
        vecs[2].iss[1]  = ins(OP_ADD, 32'd1);
        // illegal opcode 5 behaves as NOP, sets err
        vecs[3].prog[0] = ins(OP_LOAD, 32'd1);
        vecs[3].prog[1] = ins(4'h5, 32'd99);
        vecs[3].prog[2] = ins(OP_ADD, 32'd2);
        vecs[3].n_instr = 4;  vecs[3].exp_acc = 32'd3;
        vecs[3].exp_err = 1'b1;
        vecs[3].n_iss   = 2;
        vecs[3].iss[0]  = ins(OP_LOAD, 32'd1);
        vecs[3].iss[1]  = ins(OP_ADD, 32'd2);
        // first program with 3 wait states per fetch
        vecs[4]          = vecs[0];
        vecs[4].wait_cyc = 3;
        // JMP target uses low AW bits only: 0x105 -> 5
        vecs[5].prog[0] = ins(OP_JMP, 32'h105);
        vecs[5].prog[1] = ins(OP_ADD, 32'd100);
        vecs[5].prog[5] = ins(OP_LOAD, 32'd42);
        vecs[5].n_instr = 3;  vecs[5].exp_acc = 32'd42;
        vecs[5].n_iss   = 1;
        vecs[5].iss[0]  = ins(OP_LOAD, 32'd42);

        for (int i = 0; i < 256; i++) mem[i] = ins(OP_HALT, 32'd0);
        for (int i = 0; i < 16; i++) mem4[i] = ins(OP_HALT, 32'd0);
        mem4[13] = ins(OP_JMP, 32'h12);
        mem4[2]  = ins(OP_JMP, 32'd15);
        mem4[15] = ins(OP_NOP, 32'd0);
        mem4[0]  = ins(OP_HALT, 32'd0);

        for (int k = 0; k < NV; k++) begin
            do_reset();
            for (int a = 0; a < 8; a++) mem[a] = vecs[k].prog[a];
            wait_cfg  = vecs[k].wait_cyc;
            iss_q.delete();
            proto_err = 0;
            pulse_start();
            run_halt(cyc);
            check_end(k, cyc);
            chk($sformatf("v%0d halted", k), 36'(halted), 36'd1);
        end

        // err stays set across a restart from HALTED; counter restarts
        do_reset();
        for (int a = 0; a < 8; a++) mem[a] = vecs[3].prog[a];
        wait_cfg = 0;
        pulse_start();
        run_halt(cyc);
        iss_q.delete();
        pulse_start();
        chk("restart halted_low", 36'(halted), 36'd0);
        run_halt(cyc);
        chk("restart err_sticky", 36'(err), 36'd1);
        chk("restart acc", 36'(acc), 36'd3);
        chk("restart count", 36'(instr_count), PERF ? 36'd4 : 36'd0);

        // reset state, taken right after err was set
        do_reset();
        chk("rst req", 36'(imem_req), 36'd0);
        chk("rst addr", 36'(imem_addr), 36'd0);
        chk("rst opcode", 36'(opcode), 36'(OP_NOP));
        chk("rst operand", 36'(operand), 36'd0);
        chk("rst halted", 36'(halted), 36'd0);
        chk("rst err", 36'(err), 36'd0);
        chk("rst count", 36'(instr_count), 36'd0);

        // reset in the middle of a fetch, valid arriving afterwards
        mem[0] = ins(OP_LOAD, 32'd77);
        manual_mode  = 1'b1;
        manual_valid = 1'b0;
        pulse_start();
        @(posedge clk);
        #1 chk("midfetch req", 36'(imem_req), 36'd1);
        iss_q.delete();
        reset = 1'b1;
        #1 chk("midfetch async_req", 36'(imem_req), 36'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        manual_valid = 1'b1;
        @(posedge clk);
        #1 manual_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midfetch idle_req", 36'(imem_req), 36'd0);
        chk("midfetch halted", 36'(halted), 36'd0);
        chk("midfetch issues", 36'(iss_q.size()), 36'd0);
        manual_mode = 1'b0;

        // AW=4 instance: JMP 0x12 -> 2, JMP 15, NOP wraps to 0, HALT
        do_reset();
        addr4_q.delete();
        iss4 = 0;
        start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        cyc = 0;
        while (cyc < 100 && !halted4) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("aw4 cycles", 36'(cyc), 36'd8);
        chk("aw4 n_fetch", 36'(addr4_q.size()), 36'd4);
        if (addr4_q.size() == 4) begin
            chk("aw4 fetch0", 36'(addr4_q[0]), 36'd13);
            chk("aw4 fetch1", 36'(addr4_q[1]), 36'd2);
            chk("aw4 fetch2", 36'(addr4_q[2]), 36'd15);
            chk("aw4 fetch3", 36'(addr4_q[3]), 36'd0);
        end
        chk("aw4 issues", 36'(iss4), 36'd0);
        chk("aw4 err", 36'(err4), 36'd0);
        chk("aw4 addr_hold", 36'(imem_addr4), 36'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
